// File: rtl/sop_pkg.sv
// Shared constants and helpers for the programmable sum-of-products pipeline.
package sop_pkg;
  localparam logic [1:0] CFG_SEL_AND = 2'b00;
  localparam logic [1:0] CFG_SEL_POL = 2'b01;
  localparam logic [1:0] CFG_SEL_OR  = 2'b10;
  localparam int         HIT_CNT_W   = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sop_stage.sv
// One elastic register slice: loads when empty or when its contents leave this cycle.
module sop_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  input  logic         adv_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;

  assign ready_o = !valid_q | adv_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end
endmodule

// File: rtl/sop_pipe.sv
// Programmable 2-stage sum-of-products unit with valid/ready streaming.
// Optional hit counter built only when SOP_STATS_EN is defined.
module sop_pipe import sop_pkg::*; #(
  parameter  int N_IN    = 4,
  parameter  int N_TERMS = 2,
  parameter  int N_OUT   = 1,
  localparam int CFG_AW  = max_int(1, $clog2(max_int(N_TERMS, N_OUT))),
  localparam int CFG_DW  = max_int(N_IN, N_TERMS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_OUT-1:0]     out_data,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [CFG_AW-1:0]    cfg_addr,
  input  logic [CFG_DW-1:0]    cfg_data,
  input  logic                 stats_clr,
  output logic [HIT_CNT_W-1:0] hit_cnt
);
  logic [N_TERMS-1:0][N_IN-1:0]  and_q, pol_q;
  logic [N_OUT-1:0][N_TERMS-1:0] or_q;
  logic [N_TERMS-1:0]            term_d, s1_terms;
  logic [N_OUT-1:0]              or_d;
  logic                          s1_valid, s1_adv;

  // Out-of-range addresses match no index below, so such writes fall away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < N_TERMS; t++) begin
        and_q[t]                 <= '0;
        and_q[t][(2*t) % N_IN]   <= 1'b1;
        and_q[t][(2*t+1) % N_IN] <= 1'b1;
        pol_q[t]                 <= '0;
      end
      or_q <= '1;
    end else if (cfg_we) begin
      for (int t = 0; t < N_TERMS; t++) begin
        if (cfg_addr == CFG_AW'(t)) begin
          if (cfg_sel == CFG_SEL_AND) and_q[t] <= cfg_data[N_IN-1:0];
          if (cfg_sel == CFG_SEL_POL) pol_q[t] <= cfg_data[N_IN-1:0];
        end
      end
      for (int o = 0; o < N_OUT; o++) begin
        if (cfg_addr == CFG_AW'(o) && cfg_sel == CFG_SEL_OR) or_q[o] <= cfg_data[N_TERMS-1:0];
      end
    end
  end

  always_comb begin
    term_d = '0;
    for (int t = 0; t < N_TERMS; t++)
      term_d[t] = (|and_q[t]) & (&((in_data ^ pol_q[t]) | ~and_q[t]));
  end

  always_comb begin
    or_d = '0;
    for (int o = 0; o < N_OUT; o++)
      or_d[o] = |(s1_terms & or_q[o]);
  end

  sop_stage #(.W(N_TERMS)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .valid_i(in_valid), .data_i(term_d), .ready_o(in_ready),
    .adv_i(s1_adv), .valid_o(s1_valid), .data_o(s1_terms)
  );

  // Stage 2 readiness doubles as the stage 1 advance condition.
  sop_stage #(.W(N_OUT)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .valid_i(s1_valid), .data_i(or_d), .ready_o(s1_adv),
    .adv_i(out_ready), .valid_o(out_valid), .data_o(out_data)
  );

`ifdef SOP_STATS_EN
  logic [HIT_CNT_W-1:0] hit_q, hit_d;

  always_comb begin
    hit_d = hit_q;
    if (stats_clr)
      hit_d = '0;
    else if (out_valid && out_ready && (|out_data) && hit_q != '1)
      hit_d = hit_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= '0;
    else        hit_q <= hit_d;
  end

  assign hit_cnt = hit_q;
`else
  logic stats_clr_unused;
  assign stats_clr_unused = stats_clr;
  assign hit_cnt          = '0;
`endif
endmodule

// File: tb/tb_sop_pipe.sv
// Randomized + directed bench for sop_pipe against a rule-level scoreboard model.
module tb_sop_pipe;
  localparam int N_IN = 4, N_TERMS = 2, N_OUT = 1, AW = 1, DW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [N_IN-1:0]  in_data = '0;
  logic [N_OUT-1:0] out_data;
  logic cfg_we = 1'b0, stats_clr = 1'b0;
  logic [1:0] cfg_sel = 2'b00;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic [15:0] hit_cnt;

  always #5 clk = ~clk;

  sop_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .stats_clr(stats_clr), .hit_cnt(hit_cnt)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: config tables and the AND/OR rules evaluated bit by bit.
  logic [N_IN-1:0]    m_and[N_TERMS], m_pol[N_TERMS];
  logic [N_TERMS-1:0] m_or[N_OUT];
  logic [15:0]        m_hits = '0;

  function automatic void model_reset();
    for (int t = 0; t < N_TERMS; t++) begin
      m_and[t] = '0;
      m_and[t][(2*t) % N_IN] = 1'b1;
      m_and[t][(2*t+1) % N_IN] = 1'b1;
      m_pol[t] = '0;
    end
    for (int o = 0; o < N_OUT; o++) m_or[o] = '1;
  endfunction

  function automatic logic [N_OUT-1:0] model_eval(input logic [N_IN-1:0] d);
    logic [N_OUT-1:0] y = '0;
    bit hit[N_TERMS];
    for (int t = 0; t < N_TERMS; t++) begin
      hit[t] = (m_and[t] != 0);
      for (int i = 0; i < N_IN; i++)
        if (m_and[t][i] && (d[i] == m_pol[t][i])) hit[t] = 0;
    end
    for (int o = 0; o < N_OUT; o++)
      for (int t = 0; t < N_TERMS; t++)
        if (m_or[o][t] && hit[t]) y[o] = 1'b1;
    return y;
  endfunction

  function automatic void model_cfg(input logic [1:0] sel, input int a, input logic [DW-1:0] d);
    if (sel == 2'b00 && a < N_TERMS) m_and[a] = d[N_IN-1:0];
    if (sel == 2'b01 && a < N_TERMS) m_pol[a] = d[N_IN-1:0];
    if (sel == 2'b10 && a < N_OUT)   m_or[a]  = d[N_TERMS-1:0];
  endfunction

  logic [N_OUT-1:0] exp_q[$];
  int               acc_q[$];
  int               cyc = 0, n_out = 0;
  bit               chk_lat = 0, stall_prev = 0;
  logic [N_OUT-1:0] data_prev, last_out = '0, e;

  // Monitor: inputs change just after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      chk("hit_cnt", hit_cnt, m_hits);
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, data_prev);
      end
      e = '0;
      if (out_valid && out_ready) begin
        n_out++;
        last_out = out_data;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
          if (chk_lat) chk("latency", cyc - acc_q.pop_front(), 2);
          else void'(acc_q.pop_front());
        end
      end
`ifdef SOP_STATS_EN
      if (stats_clr) m_hits = '0;
      else if (out_valid && out_ready && e != 0 && m_hits != 16'hFFFF) m_hits = m_hits + 1'b1;
`endif
      if (in_valid && in_ready) begin
        exp_q.push_back(model_eval(in_data));
        acc_q.push_back(cyc);
      end
      if (cfg_we) model_cfg(cfg_sel, int'(cfg_addr), cfg_data);
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
    end else stall_prev = 0;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [N_IN-1:0] d);
    bit ok = 0;
    in_valid = 1'b1; in_data = d;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("send_accept", ok, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    tick();
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete(); acc_q.delete();
    model_reset(); m_hits = '0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  logic [N_IN-1:0] w[4];
  int              nacc, snap;
  bit              acc;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hit_cnt", hit_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Default config streams all 16 inputs back to back with latency checked.
    chk_lat = 1;
    for (int d = 0; d < 16; d++) send(N_IN'(d));
    drain();
    chk_lat = 0;
    send(4'b1100); drain(); chk("t1_1100", last_out, 1);
    send(4'b1010); drain(); chk("t1_1010", last_out, 0);

    // Programmed term with polarity, then ignored writes.
    cfg(2'b00, 1'b0, 4'b0101);
    cfg(2'b01, 1'b0, 4'b0100);
    cfg(2'b10, 1'b0, 4'b0001);
    send(4'b0001); drain(); chk("t2_0001", last_out, 1);
    send(4'b0101); drain(); chk("t2_0101", last_out, 0);
    cfg(2'b10, 1'b1, 4'b0000);
    cfg(2'b11, 1'b0, 4'b0000);
    send(4'b0001); drain(); chk("t2_ign_0001", last_out, 1);
    send(4'b0101); drain(); chk("t2_ign_0101", last_out, 0);

    // Backpressure: two words fill the pipe, then in_ready drops.
    for (int i = 0; i < 4; i++) w[i] = N_IN'($urandom);
    snap = n_out; nacc = 0; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (nacc < 4); in_data = w[nacc % 4];
      @(negedge clk);
      if (c == 2) chk("bp_in_ready", in_ready, 0);
      if (c == 4) chk("bp_out_valid", out_valid, 1);
      acc = in_valid && in_ready;
      tick();
      if (acc) nacc++;
    end
    chk("bp_accepted", nacc, 2);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = nacc; i < 4; i++) send(w[i]);
    drain();
    chk("bp_count", n_out - snap, 4);

    // Config write coinciding with an accept uses the old config.
    in_valid = 1'b1; in_data = 4'b0001;
    cfg_we = 1'b1; cfg_sel = 2'b00; cfg_addr = 1'b0; cfg_data = 4'b0000;
    @(negedge clk);
    chk("t4_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; cfg_we = 1'b0;
    drain(); chk("t4_old_cfg", last_out, 1);
    send(4'b0001); drain(); chk("t4_empty_mask", last_out, 0);

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(4'b0011); send(4'b1111);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_data", out_data, 0);
    exp_q.delete(); acc_q.delete(); model_reset(); m_hits = '0;
    @(negedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send(4'b0011); drain(); chk("t5_default_hit", last_out, 1);
    send(4'b0110); drain(); chk("t5_default_miss", last_out, 0);

    // Random traffic; OR-mask writes only with out-of-range addresses.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = N_IN'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      stats_clr = ($urandom_range(0, 15) == 0);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_sel   = 2'($urandom_range(0, 3));
      cfg_addr  = AW'($urandom);
      if (cfg_sel == 2'b10) cfg_addr = 1'b1;
      cfg_data  = DW'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0; stats_clr = 1'b0;
    drain();

    // Hit counter: 10 nonzero and 3 zero results, then clear racing a hit.
    do_reset();
    for (int i = 0; i < 13; i++) send((i < 10) ? 4'b0011 : 4'b0000);
    drain();
`ifdef SOP_STATS_EN
    chk("t6_hits", hit_cnt, 10);
`else
    chk("t6_hits", hit_cnt, 0);
`endif
    send(4'b1100);
    tick();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    @(negedge clk);
    chk("t6_clr_wins", hit_cnt, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
